// File: rtl/bram_rd_stream.sv
// bram_rd_stream: valid/ready request front end for one byte-enable
// block RAM port, with read-latency tracking and a credit-guarded
// response FIFO so read data survives consumer stalls.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake
//   i_req_we                byte enables (all zero = read)
//   i_req_addr, i_req_data  word address, write data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_data              read data, in request order
//   o_bram_en/we/addr/di    RAM port controls
//   i_bram_do               RAM read data
module bram_rd_stream #(
    parameter int PIPELINED  = 0,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int WE_WIDTH   = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [WE_WIDTH-1:0]   i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_bram_en,
    output logic [WE_WIDTH-1:0]   o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_di,
    input  logic [DATA_WIDTH-1:0] i_bram_do
);

    localparam int LAT   = 1 + PIPELINED;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

    logic                  r_live;
    logic [CNT_W-1:0]      r_credits;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [LAT-1:0]        r_tag;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_fire;
    logic                  w_rd;
    logic                  w_push;
    logic                  w_pop;
    logic [LAT:0]          w_tag_nxt;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] f_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from registered state: never from i_rsp_ready.
    assign o_req_ready = r_live & (r_credits != '0);
    assign w_fire      = i_req_valid & o_req_ready;
    assign w_rd        = w_fire & ~(|i_req_we);

    assign o_bram_en   = w_fire;
    assign o_bram_we   = i_req_we & {WE_WIDTH{w_fire}};
    assign o_bram_addr = i_req_addr;
    assign o_bram_di   = i_req_data;

    // Tag leaves the last stage exactly when the RAM output is valid.
    assign w_tag_nxt   = {r_tag, w_rd};
    assign w_push      = r_tag[LAT-1];

    assign o_rsp_valid = (r_count != '0);
    assign o_rsp_data  = r_mem[r_head];
    assign w_pop       = o_rsp_valid & i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live    <= 1'b0;
            r_credits <= C_DEPTH;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_tag     <= '0;
        end else begin
            r_live    <= 1'b1;
            r_tag     <= w_tag_nxt[LAT-1:0];
            // A read takes a credit, a pop returns one.
            r_credits <= r_credits - CNT_W'(w_rd) + CNT_W'(w_pop);
            r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_tail <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
        end
    end

    // Storage needs no reset: occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_bram_do;
        end
    end

    // Credits make this unreachable; kept as a guard.
    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && (r_count == C_DEPTH))
    );

endmodule
